// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: single-port controller for the external 8-bit SRAM, shared
// between the download loader (write), video fetch (read) and CPU/DMA bus (read/write).
// Each access runs IDLE -> SETUP -> ACCESS x ACCESS_CYCLES -> DONE, and done arrives
// 2+ACCESS_CYCLES cycles after the request is seen in IDLE. One access starts every
// 3+ACCESS_CYCLES cycles.
// A requester holds req, addr, data and we until its one-cycle done pulse. bus_ready is
// low while bus_req waits, and it feeds the chipset ready AND-term.
// Ports: dl_* download write port; vid_* video read port; bus_* CPU/DMA port plus
//        bus_ready; sram_* external SRAM pins (sram_wdata_oe drives the data pins).
// Optional: define SRAM_ARB_STARVE_GUARD_EN so that the bus ranks above video after
//           STARVE_LIMIT video grants have been made while the bus was waiting.
module sram_port_arbiter #(
   parameter int ADDR_W        = 21,
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dl_active,
   input  logic              dl_req,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   output logic              dl_done,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [7:0]        vid_data,
   output logic              vid_done,
   input  logic              bus_req,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [7:0]        bus_wdata,
   output logic [7:0]        bus_rdata,
   output logic              bus_done,
   output logic              bus_ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_wdata,
   output logic              sram_wdata_oe,
   output logic              sram_we_n,
   input  logic [7:0]        sram_rdata
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} state_t;
   typedef enum logic [1:0] {GNT_NONE, GNT_DL, GNT_VID, GNT_BUS} grant_t;

   if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15 || STARVE_LIMIT < 1) begin : g_param_check
      $error("sram_port_arbiter: ACCESS_CYCLES must be 1..15 and STARVE_LIMIT >= 1");
   end

   state_t            state, state_nx;
   grant_t            grant, grant_nx;
   logic [3:0]        acc_cnt;
   logic [ADDR_W-1:0] lat_addr, win_addr;
   logic [7:0]        lat_data, win_data;
   logic              lat_we, win_we;
   logic              bus_elig, bus_first, take_bus;
   logic              acc_last, launch, finish;

   assign bus_elig  = bus_req & ~dl_active;
   // The bus wins over video when video is idle, or when the starvation guard says so.
   assign take_bus  = bus_elig & (bus_first | ~vid_req);
   assign acc_last  = (acc_cnt == 4'(ACCESS_CYCLES - 1));
   assign launch    = (state == ST_IDLE) && (state_nx == ST_SETUP);
   assign finish    = (state == ST_ACCESS) && acc_last;

   // The pins follow the latched request, so sram_addr holds its value while in IDLE.
   assign sram_addr  = lat_addr;
   assign sram_wdata = lat_data;
   // bus_done is registered, so ready rises in the same cycle as the done pulse.
   assign bus_ready  = ~(bus_req & ~bus_done);

`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;

   assign bus_first = (starve_cnt >= SW'(STARVE_LIMIT));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!bus_req || (launch && grant_nx == GNT_BUS)) begin
         starve_cnt <= '0;
      end else if (launch && grant_nx == GNT_VID && bus_elig && !bus_first) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign bus_first = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         grant <= GNT_NONE;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      win_addr = lat_addr;
      win_data = lat_data;
      win_we   = lat_we;
      unique case (state)
         ST_IDLE: begin
            grant_nx = GNT_NONE;
            if (dl_req) begin
               grant_nx = GNT_DL;
               win_addr = dl_addr;
               win_data = dl_data;
               win_we   = 1'b1;
            end else if (take_bus) begin
               grant_nx = GNT_BUS;
               win_addr = bus_addr;
               win_data = bus_wdata;
               win_we   = bus_we;
            end else if (vid_req) begin
               grant_nx = GNT_VID;
               win_addr = vid_addr;
               win_we   = 1'b0;
            end
            if (grant_nx != GNT_NONE) state_nx = ST_SETUP;
         end
         ST_SETUP:  state_nx = ST_ACCESS;
         ST_ACCESS: if (acc_last) state_nx = ST_DONE;
         ST_DONE: begin
            state_nx = ST_IDLE;
            grant_nx = GNT_NONE;
         end
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_addr      <= '0;
         lat_data      <= '0;
         lat_we        <= 1'b0;
         acc_cnt       <= '0;
         sram_wdata_oe <= 1'b0;
         sram_we_n     <= 1'b1;
         dl_done       <= 1'b0;
         vid_done      <= 1'b0;
         bus_done      <= 1'b0;
         vid_data      <= '0;
         bus_rdata     <= '0;
      end else begin
         if (launch) begin
            lat_addr <= win_addr;
            lat_data <= win_data;
            lat_we   <= win_we;
         end
         acc_cnt <= (state == ST_ACCESS) ? acc_cnt + 4'd1 : 4'd0;
         // Drive the data pins from SETUP through DONE, so that the data hold covers the
         // rising edge of the strobe.
         if (launch)
            sram_wdata_oe <= win_we;
         else if (state == ST_DONE)
            sram_wdata_oe <= 1'b0;
         sram_we_n <= ~(lat_we & (state_nx == ST_ACCESS));
         dl_done   <= finish & (grant == GNT_DL);
         vid_done  <= finish & (grant == GNT_VID);
         bus_done  <= finish & (grant == GNT_BUS);
         if (finish && grant == GNT_VID)
            vid_data <= sram_rdata;
         if (finish && grant == GNT_BUS && !lat_we)
            bus_rdata <= sram_rdata;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
   localparam int AW     = 21;
   localparam int AC     = 2;
   localparam int LAT    = 2 + AC;
   localparam int PERIOD = 3 + AC;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic          dl_active = 0, dl_req = 0, vid_req = 0, bus_req = 0, bus_we = 0;
   logic [AW-1:0] dl_addr = '0, vid_addr = '0, bus_addr = '0;
   logic [7:0]    dl_data = '0, bus_wdata = '0;
   logic          dl_done, vid_done, bus_done, bus_ready, sram_wdata_oe, sram_we_n;
   logic [7:0]    vid_data, bus_rdata, sram_wdata, sram_rdata;
   logic [AW-1:0] sram_addr;

   // Second instance with a one-cycle strobe, used only through its bus port.
   logic          b_req = 0, b_we = 0;
   logic [AW-1:0] b_addr = '0;
   logic [7:0]    b_wdata = '0;
   logic          zero1 = 1'b0;
   logic [AW-1:0] zero_a = '0;
   logic [7:0]    zero8 = '0;
   logic          b_dl_done, b_vid_done, b_done, b_ready, b_oe, b_we_n;
   logic [7:0]    b_vid_data, b_rdata, b_sram_wdata;
   logic [AW-1:0] b_sram_addr;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural SRAM behind the main instance, plus the bench's expected contents.
   logic       mem_clear = 1'b1;
   logic [7:0] mem     [0:4095];
   logic [7:0] exp_mem [0:4095];
   always @(posedge clock) begin
      if (mem_clear) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      end else if (!sram_we_n) begin
         mem[sram_addr[11:0]] <= sram_wdata;
      end
   end
   assign sram_rdata = mem[sram_addr[11:0]];

   sram_port_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(AC), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset), .dl_active(dl_active),
      .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_done(dl_done),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_done(vid_done),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_done(bus_done), .bus_ready(bus_ready),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
      .sram_we_n(sram_we_n), .sram_rdata(sram_rdata));

   sram_port_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(1), .STARVE_LIMIT(4)) dut1 (
      .clock(clock), .reset(reset), .dl_active(zero1),
      .dl_req(zero1), .dl_addr(zero_a), .dl_data(zero8), .dl_done(b_dl_done),
      .vid_req(zero1), .vid_addr(zero_a), .vid_data(b_vid_data), .vid_done(b_vid_done),
      .bus_req(b_req), .bus_we(b_we), .bus_addr(b_addr), .bus_wdata(b_wdata),
      .bus_rdata(b_rdata), .bus_done(b_done), .bus_ready(b_ready),
      .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_wdata_oe(b_oe),
      .sram_we_n(b_we_n), .sram_rdata(zero8));

   // Single bus access on the main instance; lat = cycles from request to done, -1 on timeout.
   task automatic bus_op(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd);
      lat = -1; rd = 8'h00;
      @(negedge clock);
      bus_req = 1; bus_we = we; bus_addr = a; bus_wdata = d;
      for (int c = 0; c < 200; c++) begin
         if (c != 0) @(negedge clock);
         #1;
         if (bus_done) begin lat = c; rd = bus_rdata; bus_req = 0; break; end
      end
      bus_req = 0;
   endtask

   // Raise any subset of the three requests in one cycle and record when each completes.
   task automatic concurrent_op(input logic [2:0] mask, input logic [AW-1:0] da, input logic [7:0] dd,
                                input logic [AW-1:0] va, input logic bw, input logic [AW-1:0] ba,
                                input logic [7:0] bd, output int dc, output int vc, output int bc,
                                output logic [7:0] vr, output logic [7:0] br);
      dc = -1; vc = -1; bc = -1; vr = 8'h00; br = 8'h00;
      @(negedge clock);
      dl_req = mask[0]; dl_addr = da; dl_data = dd;
      vid_req = mask[1]; vid_addr = va;
      bus_req = mask[2]; bus_we = bw; bus_addr = ba; bus_wdata = bd;
      for (int c = 0; c < 40; c++) begin
         if (c != 0) @(negedge clock);
         #1;
         if (dl_done)  begin dc = c; dl_req = 0; end
         if (vid_done) begin vc = c; vr = vid_data; vid_req = 0; end
         if (bus_done) begin bc = c; br = bus_rdata; bus_req = 0; end
      end
      dl_req = 0; vid_req = 0; bus_req = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4096; i++) exp_mem[i] = 8'h00;
      @(negedge clock); #1;
      n_tests++;
      if (sram_addr !== '0 || sram_wdata !== 8'h00) begin
         n_fail++; $display("FAIL reset_pins: addr=%h wdata=%h required 0/0", sram_addr, sram_wdata);
      end
      n_tests++;
      if ({sram_wdata_oe, sram_we_n, dl_done, vid_done, bus_done, bus_ready} !== 6'b010001) begin
         n_fail++;
         $display("FAIL reset_ctrl: oe,we_n,dl,vid,bus_done,ready=%b required 010001",
                  {sram_wdata_oe, sram_we_n, dl_done, vid_done, bus_done, bus_ready});
      end
      n_tests++;
      if (vid_data !== 8'h00 || bus_rdata !== 8'h00) begin
         n_fail++; $display("FAIL reset_rdata: vid=%h bus=%h required 00/00", vid_data, bus_rdata);
      end
      @(negedge clock);
      reset = 0; mem_clear = 0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_bus_write();
      logic [5:0] we_n_obs, done_obs, rdy_obs;
      logic [AW-1:0] addr_c2;
      int lat;
      logic [7:0] rd;
      addr_c2 = '0;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clock);
         if (c == 0) begin bus_req = 1; bus_we = 1; bus_addr = 21'h00123; bus_wdata = 8'hA5; end
         #1;
         we_n_obs[c] = sram_we_n; done_obs[c] = bus_done; rdy_obs[c] = bus_ready;
         if (c == 2) addr_c2 = sram_addr;
         if (bus_done) bus_req = 0;
      end
      exp_mem[12'h123] = 8'hA5;
      n_tests++;
      if (we_n_obs !== 6'b110011) begin n_fail++; $display("FAIL write_we_n: cycles5..0=%b required 110011", we_n_obs); end
      n_tests++;
      if (done_obs !== 6'b010000) begin n_fail++; $display("FAIL write_done: cycles5..0=%b required 010000", done_obs); end
      n_tests++;
      if (rdy_obs !== 6'b110000) begin n_fail++; $display("FAIL write_ready: cycles5..0=%b required 110000", rdy_obs); end
      n_tests++;
      if (addr_c2 !== 21'h00123) begin n_fail++; $display("FAIL write_addr: got %h required 00123", addr_c2); end
      bus_op(1'b0, 21'h00123, 8'h00, lat, rd);
      n_tests++;
      if (lat !== LAT || rd !== 8'hA5) begin
         n_fail++; $display("FAIL readback: lat=%0d data=%h required %0d/A5", lat, rd, LAT);
      end
   endtask

   task automatic test_simultaneous();
      int dc, vc, bc;
      logic [7:0] vr, br;
      concurrent_op(3'b111, 21'h010, 8'h5A, 21'h123, 1'b0, 21'h010, 8'h00, dc, vc, bc, vr, br);
      exp_mem[12'h010] = 8'h5A;
      n_tests++;
      if (dc !== 4 || vc !== 9 || bc !== 14) begin
         n_fail++; $display("FAIL simul_order: dl=%0d vid=%0d bus=%0d required 4/9/14", dc, vc, bc);
      end
      n_tests++;
      if (vr !== 8'hA5 || br !== 8'h5A) begin
         n_fail++; $display("FAIL simul_data: vid=%h bus=%h required A5/5A", vr, br);
      end
   endtask

   task automatic test_dl_lockout();
      int bad_rdy = 0, bad_done = 0, vc = -1, bc = -1;
      logic [7:0] vr = 8'h00, br = 8'h00;
      @(negedge clock);
      dl_active = 1; bus_req = 1; bus_we = 0; bus_addr = 21'h010;
      for (int c = 0; c < 50; c++) begin
         if (c != 0) @(negedge clock);
         if (c == 10) begin vid_req = 1; vid_addr = 21'h123; end
         #1;
         if (bus_ready !== 1'b0) bad_rdy++;
         if (bus_done) bad_done++;
         if (vid_done) begin vc = c; vr = vid_data; vid_req = 0; end
      end
      n_tests++;
      if (bad_rdy != 0 || bad_done != 0) begin
         n_fail++; $display("FAIL lockout: ready-high cycles=%0d done pulses=%0d required 0/0", bad_rdy, bad_done);
      end
      n_tests++;
      if (vc !== 14 || vr !== exp_mem[12'h123]) begin
         n_fail++; $display("FAIL lockout_vid: cycle=%0d data=%h required 14/%h", vc, vr, exp_mem[12'h123]);
      end
      @(negedge clock);
      dl_active = 0;
      for (int c = 0; c < 20; c++) begin
         if (c != 0) @(negedge clock);
         #1;
         if (bus_done) begin bc = c; br = bus_rdata; bus_req = 0; break; end
      end
      bus_req = 0;
      n_tests++;
      if (bc !== LAT || br !== exp_mem[12'h010]) begin
         n_fail++; $display("FAIL lockout_release: cycle=%0d data=%h required %0d/%h", bc, br, LAT, exp_mem[12'h010]);
      end
      // dl_active rising after the grant must not disturb the access in flight.
      bc = -1;
      @(negedge clock);
      bus_req = 1; bus_we = 1; bus_addr = 21'h011; bus_wdata = 8'h77;
      for (int c = 0; c < 20; c++) begin
         if (c != 0) @(negedge clock);
         if (c == 2) dl_active = 1;
         #1;
         if (bus_done) begin bc = c; bus_req = 0; break; end
      end
      bus_req = 0; dl_active = 0;
      exp_mem[12'h011] = 8'h77;
      n_tests++;
      if (bc !== LAT) begin n_fail++; $display("FAIL inflight_dl_active: cycle=%0d required %0d", bc, LAT); end
   endtask

   task automatic test_reset_mid_access();
      int early = 0, bc = -1, lat;
      logic [7:0] rd;
      @(negedge clock);
      bus_req = 1; bus_we = 1; bus_addr = 21'h02A; bus_wdata = 8'hC3;
      repeat (2) @(negedge clock);
      #1;
      n_tests++;
      if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL abort_pre: we_n=%b required 0", sram_we_n); end
      reset = 1;
      #1;
      n_tests++;
      if (sram_we_n !== 1'b1 || sram_wdata_oe !== 1'b0 || bus_rdata !== 8'h00) begin
         n_fail++; $display("FAIL abort_pins: we_n=%b oe=%b rdata=%h required 1/0/00", sram_we_n, sram_wdata_oe, bus_rdata);
      end
      @(negedge clock); #1;
      if (bus_done) early++;
      @(negedge clock);
      reset = 0;
      for (int c = 0; c < 20; c++) begin
         if (c != 0) @(negedge clock);
         #1;
         if (bus_done) begin bc = c; bus_req = 0; break; end
      end
      bus_req = 0;
      exp_mem[12'h02A] = 8'hC3;
      n_tests++;
      if (early != 0 || bc !== LAT) begin
         n_fail++; $display("FAIL abort_retry: done-during-reset=%0d retry cycle=%0d required 0/%0d", early, bc, LAT);
      end
      bus_op(1'b0, 21'h02A, 8'h00, lat, rd);
      n_tests++;
      if (rd !== 8'hC3) begin n_fail++; $display("FAIL abort_readback: got %h required C3", rd); end
   endtask

   task automatic test_back_to_back();
      int t[4];
      logic [7:0] d[4];
      int k = 0, lat;
      logic [7:0] rd;
      for (int i = 0; i < 4; i++) begin t[i] = -1; d[i] = 8'($urandom); end
      @(negedge clock);
      bus_req = 1; bus_we = 1; bus_addr = 21'h020; bus_wdata = d[0];
      for (int c = 0; c < 60 && k < 4; c++) begin
         if (c != 0) @(negedge clock);
         if (!bus_req) begin bus_addr = AW'(32 + k); bus_wdata = d[k]; bus_req = 1; end
         #1;
         if (bus_done) begin t[k] = c; k++; bus_req = 0; end
      end
      bus_req = 0;
      for (int i = 0; i < 4; i++) begin
         exp_mem[32 + i] = d[i];
         n_tests++;
         if (t[i] !== LAT + PERIOD * i) begin
            n_fail++; $display("FAIL b2b_cycle%0d: got %0d required %0d", i, t[i], LAT + PERIOD * i);
         end
      end
      for (int i = 0; i < 4; i++) begin
         bus_op(1'b0, AW'(32 + i), 8'h00, lat, rd);
         n_tests++;
         if (rd !== exp_mem[32 + i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h required %h", i, rd, exp_mem[32 + i]); end
      end
   endtask

   task automatic test_starve();
      int nv = 0, nv_at_bus = -1, bc = -1;
      logic [7:0] br = 8'h00;
      @(negedge clock);
      vid_req = 1; vid_addr = 21'h010; bus_req = 1; bus_we = 0; bus_addr = 21'h123;
      for (int c = 0; c < 100; c++) begin
         if (c != 0) @(negedge clock);
         #1;
         if (vid_done) nv++;
         if (bus_done && bc < 0) begin bc = c; nv_at_bus = nv; br = bus_rdata; bus_req = 0; end
      end
      bus_req = 0; vid_req = 0;
      repeat (10) @(negedge clock);
`ifdef SRAM_ARB_STARVE_GUARD_EN
      n_tests++;
      if (nv_at_bus !== 4 || bc !== LAT + 4 * PERIOD) begin
         n_fail++; $display("FAIL starve_guard: vid dones before bus=%0d bus cycle=%0d required 4/%0d", nv_at_bus, bc, LAT + 4 * PERIOD);
      end
      n_tests++;
      if (br !== exp_mem[12'h123]) begin n_fail++; $display("FAIL starve_data: got %h required %h", br, exp_mem[12'h123]); end
`else
      n_tests++;
      if (bc !== -1) begin n_fail++; $display("FAIL starve_strict: bus done at %0d required none in 100 cycles", bc); end
      n_tests++;
      if (nv !== 20) begin n_fail++; $display("FAIL starve_vid_rate: vid dones=%0d required 20", nv); end
`endif
   endtask

   task automatic test_write_hold();
      int oe_bad = 0, addr_bad = 0, wd_bad = 0, we_low = 0, we_cyc = -1, dc = -1, oe_after = 0;
      @(negedge clock);
      b_req = 1; b_we = 1; b_addr = 21'h1ABCDE; b_wdata = 8'h3C;
      for (int c = 0; c < 8; c++) begin
         if (c != 0) @(negedge clock);
         #1;
         if (c >= 1 && c <= 3) begin
            if (b_oe !== 1'b1) oe_bad++;
            if (b_sram_addr !== 21'h1ABCDE) addr_bad++;
            if (b_sram_wdata !== 8'h3C) wd_bad++;
         end
         if (c >= 4 && b_oe !== 1'b0) oe_after++;
         if (b_we_n === 1'b0) begin we_low++; we_cyc = c; end
         if (b_done) begin dc = c; b_req = 0; end
         // Inputs wiggle after latching; the access in flight must not follow them.
         if (c == 1) begin b_addr = 21'h00555; b_wdata = 8'hFF; end
      end
      b_req = 0;
      n_tests++;
      if (oe_bad != 0 || oe_after != 0) begin
         n_fail++; $display("FAIL hold_oe: off in setup..done=%0d on after done=%0d required 0/0", oe_bad, oe_after);
      end
      n_tests++;
      if (addr_bad != 0 || wd_bad != 0) begin
         n_fail++; $display("FAIL hold_addr_data: addr changes=%0d data changes=%0d required 0/0", addr_bad, wd_bad);
      end
      n_tests++;
      if (we_low !== 1 || we_cyc !== 2 || dc !== 3) begin
         n_fail++; $display("FAIL hold_strobe: we low cycles=%0d at=%0d done=%0d required 1/2/3", we_low, we_cyc, dc);
      end
   endtask

   task automatic test_random();
      logic [2:0] mask;
      logic [AW-1:0] da, va, ba;
      logic [7:0] dd, bd, ev, eb, vr, br;
      logic bw;
      int edc, evc, ebc, slot, dc, vc, bc;
      for (int it = 0; it < 40; it++) begin
         mask = 3'($urandom_range(1, 7));
         da = AW'($urandom_range(0, 15)); va = AW'($urandom_range(0, 15)); ba = AW'($urandom_range(0, 15));
         dd = 8'($urandom); bd = 8'($urandom); bw = 1'($urandom);
         // Reference: requests are served one at a time in dl, vid, bus order.
         slot = 0; edc = -1; evc = -1; ebc = -1; ev = 8'h00; eb = 8'h00;
         if (mask[0]) begin edc = LAT + PERIOD * slot; slot++; exp_mem[da] = dd; end
         if (mask[1]) begin evc = LAT + PERIOD * slot; slot++; ev = exp_mem[va]; end
         if (mask[2]) begin
            ebc = LAT + PERIOD * slot; slot++;
            if (bw) exp_mem[ba] = bd; else eb = exp_mem[ba];
         end
         concurrent_op(mask, da, dd, va, bw, ba, bd, dc, vc, bc, vr, br);
         n_tests++;
         if (dc !== edc || vc !== evc || bc !== ebc) begin
            n_fail++; $display("FAIL rand%0d_timing: mask=%b dl/vid/bus=%0d/%0d/%0d required %0d/%0d/%0d",
                               it, mask, dc, vc, bc, edc, evc, ebc);
         end
         if (mask[1]) begin
            n_tests++;
            if (vr !== ev) begin n_fail++; $display("FAIL rand%0d_vid: got %h required %h", it, vr, ev); end
         end
         if (mask[2] && !bw) begin
            n_tests++;
            if (br !== eb) begin n_fail++; $display("FAIL rand%0d_bus: got %h required %h", it, br, eb); end
         end
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end
   endtask

   initial begin
      test_reset();
      test_bus_write();
      test_simultaneous();
      test_dl_lockout();
      test_reset_mid_access();
      test_back_to_back();
      test_starve();
      test_write_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
